// File: rtl/ram_responder.sv
// ram_responder
//   Single-port word RAM that answers CPU read/write requests after a fixed
//   number of wait cycles. A request is captured in IDLE, and the FSM waits
//   WAIT_STATES cycles. The access is then performed in RESP, and a one-cycle
//   ram_ready pulse follows. If read and write are requested together, the
//   request is rejected with a one-cycle ram_error pulse.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous active-low reset (memory contents survive it)
//   ram_read     : read request
//   ram_write    : write request
//   ram_addr     : 6-bit word address of the request
//   ram_wdata    : 16-bit write data
//   ram_rdata    : 16-bit read data, valid while ram_ready is high, held until next read
//   ram_ready    : one-cycle completion pulse
//   ram_error    : one-cycle pulse for a rejected (read+write) request
//   busy         : high while an access is in progress (WAIT or RESP)
//   access_count : 8-bit wrapping count of completed accesses
module ram_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [5:0]  ram_addr,
    input  logic [15:0] ram_wdata,
    output logic [15:0] ram_rdata,
    output logic        ram_ready,
    output logic        ram_error,
    output logic        busy,
    output logic [7:0]  access_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter is loaded with WAIT_STATES-1 because the cycle that sees
    // zero is itself the last wait cycle.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [15:0] mem [0:DEPTH-1];

    state_t      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [5:0]  addr_q,       addr_d;
    logic [15:0] wdata_q,      wdata_d;
    logic        is_write_q,   is_write_d;
    logic [15:0] rdata_q,      rdata_d;
    logic        ready_q,      ready_d;
    logic        error_q,      error_d;
    logic [7:0]  count_q,      count_d;
    logic        mem_we;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        count_d    = count_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ram_read ^ ram_write) begin
                    addr_d     = ram_addr;
                    wdata_d    = ram_wdata;
                    is_write_d = ram_write;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end else if (ram_read && ram_write) begin
                    // Ambiguous request: nothing is captured and the FSM stays idle.
                    error_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                ready_d = 1'b1;
                count_d = count_q + 8'd1;
                if (is_write_q) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = mem[addr_q];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    // Captured request fields need no reset: they are only consulted after a
    // fresh capture in IDLE.
    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        is_write_q <= is_write_d;
    end

    // Reset forces IDLE asynchronously, so an abandoned write never reaches
    // the array; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign ram_rdata    = rdata_q;
    assign ram_ready    = ready_q;
    assign ram_error    = error_q;
    assign busy         = (state_q != IDLE);
    assign access_count = count_q;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready, error, busy;
    logic [7:0]  count;

    logic        rd0, wr0;
    logic [5:0]  addr0;
    logic [15:0] wdata0;
    logic [15:0] rdata0;
    logic        ready0, error0, busy0;
    logic [7:0]  count0;

    always #5 clk = ~clk;

    ram_responder #(.WAIT_STATES(W), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .ram_read(rd), .ram_write(wr), .ram_addr(addr),
        .ram_wdata(wdata), .ram_rdata(rdata), .ram_ready(ready), .ram_error(error),
        .busy(busy), .access_count(count)
    );

    ram_responder #(.WAIT_STATES(0), .DEPTH(64)) dut0 (
        .clk(clk), .reset(reset), .ram_read(rd0), .ram_write(wr0), .ram_addr(addr0),
        .ram_wdata(wdata0), .ram_rdata(rdata0), .ram_ready(ready0), .ram_error(error0),
        .busy(busy0), .access_count(count0)
    );

    // Reference model: memory image, last read value, completed-access count.
    logic [15:0] m_mem [64];
    logic [15:0] m_rdata;
    logic [7:0]  m_count;
    int n_cmp = 0;
    int n_fail = 0;

    // One complete access on the WAIT_STATES=2 instance. With scramble set,
    // address and data are changed while the access is in flight.
    task automatic access(input logic is_wr, input logic [5:0] a, input logic [15:0] d,
                          input logic scramble);
        int edges;
        logic seen;
        @(negedge clk);
        rd = ~is_wr; wr = is_wr; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        if (scramble) begin
            addr  = a ^ 6'h0A;
            wdata = ~d;
        end
        n_cmp++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_fail++; $display("FAIL acc_busy_after_capture busy=%b ready=%b exp busy=1 ready=0", busy, ready);
        end
        if (is_wr) m_mem[a] = d;
        else       m_rdata = m_mem[a];
        m_count = m_count + 8'd1;
        edges = 0; seen = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || edges != W + 1) begin
            n_fail++; $display("FAIL acc_latency edges=%0d seen=%b exp=%0d", edges, seen, W + 1);
        end
        n_cmp++;
        if (rdata !== m_rdata) begin
            n_fail++; $display("FAIL acc_rdata addr=%0d act=%h exp=%h", a, rdata, m_rdata);
        end
        n_cmp++;
        if (count !== m_count || busy !== 1'b0) begin
            n_fail++; $display("FAIL acc_count act=%0d busy=%b exp=%0d busy=0", count, busy, m_count);
        end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL acc_ready_width act=%b exp=0", ready);
        end
        addr = 6'($urandom); wdata = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rd = 0; wr = 0; addr = 0; wdata = 0;
        rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        m_rdata = 16'd0; m_count = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rdata, ready, error, busy, count} !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs rdata=%h ready=%b error=%b busy=%b count=%0d exp all 0",
                                rdata, ready, error, busy, count);
        end
        n_cmp++;
        if ({rdata0, ready0, error0, busy0, count0} !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs0 rdata=%h ready=%b error=%b busy=%b count=%0d exp all 0",
                                rdata0, ready0, error0, busy0, count0);
        end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int a = 0; a < 64; a++) access(1'b1, 6'(a), 16'($urandom), 1'b0);
    endtask

    task automatic test_write_read();
        access(1'b1, 6'd5, 16'hBEEF, 1'b0);
        access(1'b0, 6'd5, 16'h0000, 1'b0);
        n_cmp++;
        if (rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL write_read_beef act=%h exp=beef", rdata);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            access(1'($urandom), 6'($urandom), 16'($urandom), 1'b1);
    endtask

    task automatic test_write_keeps_rdata();
        logic [5:0]  a;
        logic [15:0] got;
        a = 6'($urandom);
        access(1'b0, a, 16'h0, 1'b0);
        got = m_mem[a];
        access(1'b1, a, ~got, 1'b0);
        n_cmp++;
        if (rdata !== got) begin
            n_fail++; $display("FAIL write_keeps_rdata act=%h exp=%h", rdata, got);
        end
    endtask

    task automatic test_ignore_inputs();
        access(1'b1, 6'd3, 16'h1234, 1'b1);
        access(1'b0, 6'd3, 16'h0, 1'b0);
        n_cmp++;
        if (rdata !== 16'h1234) begin
            n_fail++; $display("FAIL ignore_inputs_addr3 act=%h exp=1234", rdata);
        end
        access(1'b0, 6'd3 ^ 6'h0A, 16'h0, 1'b0);
    endtask

    task automatic test_error();
        logic [5:0] a;
        a = 6'($urandom);
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = a; wdata = ~m_mem[a];
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL error_pulse error=%b busy=%b ready=%b exp 1/0/0", error, busy, ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (error !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || count !== m_count) begin
                n_fail++; $display("FAIL error_after error=%b busy=%b ready=%b count=%0d exp 0/0/0/%0d",
                                    error, busy, ready, count, m_count);
            end
        end
        access(1'b0, a, 16'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        access(1'b1, 6'd7, 16'h5555, 1'b0);
        @(negedge clk);
        wr = 1'b1; addr = 6'd7; wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_busy_before act=%b exp=1", busy);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({rdata, ready, error, busy, count} !== 27'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs rdata=%h ready=%b error=%b busy=%b count=%0d exp all 0",
                                rdata, ready, error, busy, count);
        end
        m_rdata = 16'd0; m_count = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 6'd7, 16'h0, 1'b0);
        n_cmp++;
        if (rdata !== 16'h5555) begin
            n_fail++; $display("FAIL reset_mid_abandoned act=%h exp=5555", rdata);
        end
    endtask

    task automatic test_count_wrap();
        // One access already completed since the last reset; 256 more make 257.
        for (int i = 0; i < 256; i++)
            access(1'($urandom), 6'($urandom), 16'($urandom), 1'b0);
        n_cmp++;
        if (count !== 8'd1) begin
            n_fail++; $display("FAIL count_wrap act=%0d exp=1", count);
        end
    endtask

    task automatic test_zero_wait();
        int lowrun;
        int pulses;
        @(negedge clk);
        wr0 = 1'b1; addr0 = 6'd12; wdata0 = 16'hC0DE;
        @(posedge clk);
        @(negedge clk);
        wr0 = 1'b0; wdata0 = 16'hFFFF;
        n_cmp++;
        if (ready0 !== 1'b0 || busy0 !== 1'b1) begin
            n_fail++; $display("FAIL zw_capture ready=%b busy=%b exp 0/1", ready0, busy0);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ready0 !== 1'b1) begin
            n_fail++; $display("FAIL zw_write_latency ready=%b exp=1", ready0);
        end
        rd0 = 1'b1;
        lowrun = 0; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready0 === 1'b1) pulses++;
            n_cmp++;
            if (ready0 !== 1'((i % 2) == 1)) begin
                n_fail++; $display("FAIL zw_ready_pattern cycle=%0d act=%b exp=%b", i, ready0, 1'((i % 2) == 1));
            end
            if (ready0 === 1'b1) begin
                n_cmp++;
                if (rdata0 !== 16'hC0DE) begin
                    n_fail++; $display("FAIL zw_rdata cycle=%0d act=%h exp=c0de", i, rdata0);
                end
            end
            if (busy0 === 1'b0) lowrun++;
            else lowrun = 0;
            n_cmp++;
            if (lowrun > 1) begin
                n_fail++; $display("FAIL zw_busy_low_run cycle=%0d run=%0d exp<=1", i, lowrun);
            end
        end
        rd0 = 1'b0;
        n_cmp++;
        if (pulses != 6) begin
            n_fail++; $display("FAIL zw_pulse_count act=%0d exp=6", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_random();
        test_write_keeps_rdata();
        test_ignore_inputs();
        test_error();
        test_reset_mid();
        test_count_wrap();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, meaning the number of wait cycles between request capture and response (legal 0-15).
REQ-002 SHALL have parameter DEPTH, default 64, meaning the number of 16-bit data words (addressed by ram_addr).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ram_read  input  1  read request from CPU.
REQ-006 ram_write  input  1  write request from CPU.
REQ-007 ram_addr  input  6  word address of the request.
REQ-008 ram_wdata  input  16  write data (driven by CPU ram_data_out).
REQ-009 ram_rdata  output  16  read data returned to CPU (feeds CPU ram_data_in).
REQ-010 ram_ready  output  1  one-cycle pulse marking completion of an access.
REQ-011 ram_error  output  1  one-cycle pulse marking a rejected request.
REQ-012 busy  output  1  high while an access is in progress (states WAIT and RESP).
REQ-013 access_count  output  8  count of completed accesses, reads plus writes.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE, exactly one of ram_read/ram_write high SHALL capture ram_addr, ram_wdata and the operation type into internal registers on that edge.
REQ-016 After capture, if WAIT_STATES > 0, SHALL enter WAIT and load a wait counter with WAIT_STATES-1; if WAIT_STATES = 0, SHALL enter RESP directly.
REQ-017 In WAIT, SHALL decrement the counter each cycle and enter RESP on the cycle the counter is 0.
REQ-018 Request inputs SHALL be ignored in WAIT and RESP; captured values alone determine the access.
REQ-019 In RESP, a captured write SHALL store captured data at the captured address at the end of that cycle; a captured read SHALL load ram_rdata from the captured address at the end of that cycle.
REQ-020 ram_ready SHALL be high during the cycle after RESP (registered), exactly one cycle, and ram_rdata SHALL be valid when ram_ready is high.
REQ-021 Latency: request visible at edge N -> ram_ready high in cycle N+WAIT_STATES+2.
REQ-022 After RESP, SHALL return to IDLE; a request still asserted in IDLE SHALL start a new access (back-to-back permitted).
REQ-023 ram_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter ram_rdata, including a write to the address last read.
REQ-024 ram_read and ram_write both high in IDLE SHALL cause no capture and no memory access, SHALL pulse ram_error for one cycle (registered), and SHALL leave the FSM in IDLE.
REQ-025 access_count SHALL increment by 1 on each RESP cycle and wrap 255 -> 0.
REQ-026 access_count SHALL NOT increment on rejected requests.
REQ-027 busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-028 Addresses SHALL be used as unsigned 6-bit indices; no wrap logic beyond natural 6-bit width.

Reset
REQ-029 reset low SHALL immediately force FSM to IDLE, and force ram_rdata=0, ram_ready=0, ram_error=0, busy=0, access_count=0, and the wait counter to 0.
REQ-030 Reset asserted mid-access SHALL abandon the access; a pending write SHALL NOT be performed.
REQ-031 Memory array contents SHALL NOT be cleared by reset.
REQ-032 After reset release, the first rising edge SHALL be able to capture a request.

Verification
REQ-033 WAIT_STATES=2: write 0xBEEF to addr 5, then read addr 5 -> ram_ready high 4 cycles after each capture; ram_rdata=0xBEEF.
REQ-034 Read and write high together in IDLE -> ram_error pulses 1 cycle; busy stays 0; access_count unchanged; memory unchanged.
REQ-035 Change ram_addr/ram_wdata during WAIT of a write to addr 3 with 0x1234 -> addr 3 reads 0x1234; new addr untouched.
REQ-036 Assert reset during WAIT of a write of 0xAAAA to addr 7 (prior contents 0x5555) -> outputs 0 immediately; later read of addr 7 returns 0x5555.
REQ-037 Perform 257 completed accesses from reset -> access_count=1.
REQ-038 WAIT_STATES=0, ram_read held high continuously -> ram_ready pulses every 2 cycles; busy never low for more than 1 cycle.
